// File: rtl/channel_voice.sv
// Square-wave tone generator: phase accumulator plus two-stage amplitude pipeline.
// Each sample strobe yields one signed sample three clocks later.
module channel_voice #(
    parameter int PHASE_WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_sample_stb,
    input  logic                   i_phase_clr,
    input  logic [PHASE_WIDTH-1:0] i_phase_delta,
    input  logic [7:0]             i_top,
    input  logic                   i_top_valid,
    input  logic [8:0]             i_envelope,
    output logic signed [17:0]     o_sample,
    output logic                   o_sample_valid
);

    logic [PHASE_WIDTH-1:0] r_phase;
    logic [PHASE_WIDTH-1:0] phase_next;
    logic [7:0]             r_top;

    logic       s1_valid;
    logic       s1_sign;
    logic       s1_rest;
    logic [7:0] s1_top;
    logic [8:0] s1_env;

    logic        s2_valid;
    logic        s2_sign;
    logic [16:0] s2_mag;
    logic [17:0] s2_mag_ext;

    // A phase clear wins over the add, so a clear+strobe sample sees phase 0.
    always_comb begin
        phase_next = r_phase;
        if (i_phase_clr) begin
            phase_next = '0;
        end else if (i_sample_stb) begin
            phase_next = r_phase + i_phase_delta;
        end
    end

    assign s2_mag_ext = {1'b0, s2_mag};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase        <= '0;
            r_top          <= 8'hFF;
            s1_valid       <= 1'b0;
            s1_sign        <= 1'b0;
            s1_rest        <= 1'b0;
            s1_top         <= '0;
            s1_env         <= '0;
            s2_valid       <= 1'b0;
            s2_sign        <= 1'b0;
            s2_mag         <= '0;
            o_sample       <= '0;
            o_sample_valid <= 1'b0;
        end else begin
            r_phase <= phase_next;
            if (i_top_valid) begin
                r_top <= i_top;
            end

            // r_top is captured before any same-cycle update takes effect.
            s1_valid <= i_sample_stb;
            if (i_sample_stb) begin
                s1_sign <= phase_next[PHASE_WIDTH-1];
                s1_rest <= (i_phase_delta == '0);
                s1_top  <= r_top;
                s1_env  <= i_envelope;
            end

            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_mag   <= s1_rest ? 17'd0 : 17'(s1_top) * 17'(s1_env);

            o_sample_valid <= s2_valid;
            if (s2_valid) begin
                o_sample <= s2_sign ? -s2_mag_ext : s2_mag_ext;
            end
        end
    end

endmodule

// File: tb/tb_channel_voice.sv
// Self-checking bench for channel_voice: directed cases with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_channel_voice;

    logic               clk;
    logic               rst_n;
    logic               sample_stb;
    logic               phase_clr;
    logic [31:0]        phase_delta;
    logic [7:0]         top;
    logic               top_valid;
    logic [8:0]         envelope;
    logic signed [17:0] sample;
    logic               sample_valid;

    int n_checks = 0;
    int n_fail   = 0;

    channel_voice #(.PHASE_WIDTH(32)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_sample_stb  (sample_stb),
        .i_phase_clr   (phase_clr),
        .i_phase_delta (phase_delta),
        .i_top         (top),
        .i_top_valid   (top_valid),
        .i_envelope    (envelope),
        .o_sample      (sample),
        .o_sample_valid(sample_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int due;
        int value;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_phase;
    int          m_top;
    int          m_last;
    int          cyc;

    // Behavioural model: each strobe schedules one sample value due two edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_phase = 32'd0;
            m_top   = 255;
            m_last  = 0;
        end else begin
            int   mag;
            exp_t e;
            cyc = cyc + 1;
            if (phase_clr)       m_phase = 32'd0;
            else if (sample_stb) m_phase = m_phase + phase_delta;
            if (sample_stb) begin
                mag     = (phase_delta == 32'd0) ? 0 : m_top * int'(envelope);
                e.due   = cyc + 2;
                e.value = m_phase[31] ? -mag : mag;
                exp_q.push_back(e);
            end
            if (top_valid) m_top = int'(top);
        end
    end

    always @(negedge clk) begin
        logic exp_valid;
        exp_valid = (exp_q.size() > 0) && (exp_q[0].due == cyc) && rst_n;
        if (exp_valid) begin
            m_last = exp_q[0].value;
            void'(exp_q.pop_front());
        end
        n_checks++;
        if (sample_valid !== exp_valid) begin
            n_fail++;
            $display("[TB] FAIL valid_model cyc=%0d got=%b want=%b", cyc, sample_valid, exp_valid);
        end
        n_checks++;
        if (int'(sample) !== m_last) begin
            n_fail++;
            $display("[TB] FAIL sample_model cyc=%0d got=%0d want=%0d", cyc, sample, m_last);
        end
    end

    task automatic driveCycle(input logic stb, input logic clr, input logic [31:0] delta,
                              input logic [7:0] t, input logic tv, input logic [8:0] env);
        @(posedge clk);
        #2;
        sample_stb  = stb;
        phase_clr   = clr;
        phase_delta = delta;
        top         = t;
        top_valid   = tv;
        envelope    = env;
    endtask

    task automatic applyStimulus(input logic clr, input logic [31:0] delta,
                                 input logic [7:0] t, input logic tv, input logic [8:0] env);
        driveCycle(1'b1, clr, delta, t, tv, env);
        driveCycle(1'b0, 1'b0, delta, t, 1'b0, env);
    endtask

    task automatic checkOutput(input int want, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (sample_valid) seen = 1'b1;
        end
        n_checks++;
        if (!seen || int'(sample) != want) begin
            n_fail++;
            $display("[TB] FAIL %s got=%0d (valid seen=%b) want=%0d", name, sample, seen, want);
        end
    endtask

    task automatic checkQuiet(input int cycles, input string name);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (sample_valid) pulses++;
        end
        n_checks++;
        if (pulses != 0 || sample != 18'sd0) begin
            n_fail++;
            $display("[TB] FAIL %s got pulses=%0d sample=%0d want pulses=0 sample=0", name, pulses, sample);
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #2;
        rst_n       = 1'b0;
        sample_stb  = 1'b0;
        phase_clr   = 1'b0;
        top_valid   = 1'b0;
        phase_delta = 32'd0;
        top         = 8'd0;
        envelope    = 9'd0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        cyc         = 0;
        rst_n       = 1'b1;
        sample_stb  = 1'b0;
        phase_clr   = 1'b0;
        phase_delta = 32'd0;
        top         = 8'd0;
        top_valid   = 1'b0;
        envelope    = 9'd0;
        #1 rst_n = 1'b0;

        // Reset and first strobe
        doReset();
        checkQuiet(6, "reset_idle");
        applyStimulus(1'b0, 32'h4000_0000, 8'h00, 1'b0, 9'd30);
        checkOutput(7650, "first_strobe");

        // Wave sequence
        doReset();
        applyStimulus(1'b0, 32'h4000_0000, 8'h00, 1'b0, 9'd30);
        checkOutput(7650, "wave0");
        repeat (2) @(posedge clk);
        applyStimulus(1'b0, 32'h4000_0000, 8'h00, 1'b0, 9'd30);
        checkOutput(-7650, "wave1");
        repeat (2) @(posedge clk);
        applyStimulus(1'b0, 32'h4000_0000, 8'h00, 1'b0, 9'd30);
        checkOutput(-7650, "wave2");
        repeat (2) @(posedge clk);
        applyStimulus(1'b0, 32'h4000_0000, 8'h00, 1'b0, 9'd30);
        checkOutput(7650, "wave3");

        // Extremes and rest
        doReset();
        applyStimulus(1'b0, 32'h8000_0000, 8'h00, 1'b0, 9'd511);
        checkOutput(-130305, "max_negative");
        applyStimulus(1'b0, 32'h8000_0000, 8'h00, 1'b0, 9'd511);
        checkOutput(130305, "max_positive");
        applyStimulus(1'b0, 32'h0000_0000, 8'h00, 1'b0, 9'd511);
        checkOutput(0, "rest_zero");

        // Top capture
        doReset();
        applyStimulus(1'b0, 32'h4000_0000, 8'h10, 1'b1, 9'd30);
        checkOutput(7650, "top_old_used");
        applyStimulus(1'b0, 32'h4000_0000, 8'h55, 1'b0, 9'd30);
        checkOutput(-480, "top_new_used");

        // Phase clear with strobe
        doReset();
        applyStimulus(1'b0, 32'hC000_0000, 8'h00, 1'b0, 9'd30);
        checkOutput(-7650, "phase_c0");
        applyStimulus(1'b1, 32'h4000_0000, 8'h00, 1'b0, 9'd30);
        checkOutput(7650, "clr_strobe");
        applyStimulus(1'b0, 32'h4000_0000, 8'h00, 1'b0, 9'd30);
        checkOutput(7650, "after_clr");

        // Randomized traffic checked by the model
        for (int i = 0; i < 2000; i++) begin
            driveCycle($urandom_range(1) == 1, $urandom_range(9) == 0,
                       ($urandom_range(4) == 0) ? 32'd0 : $urandom,
                       8'($urandom), $urandom_range(4) == 0, 9'($urandom));
        end
        driveCycle(1'b0, 1'b0, 32'd0, 8'd0, 1'b0, 9'd0);
        repeat (5) @(posedge clk);

        // Back-to-back strobes, then reset with samples in flight
        doReset();
        repeat (3) driveCycle(1'b1, 1'b0, 32'h4000_0000, 8'h00, 1'b0, 9'd30);
        driveCycle(1'b0, 1'b0, 32'h4000_0000, 8'h00, 1'b0, 9'd30);
        repeat (6) @(posedge clk);
        repeat (3) driveCycle(1'b1, 1'b0, 32'h4000_0000, 8'h00, 1'b0, 9'd30);
        sample_stb = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        checkQuiet(6, "reset_flush");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
